fifo_uart_tx: RTL and testbench

Serial transmitter on the read side of the dual-clock FIFO. It pops bytes from the FIFO read port whenever the FIFO is non-empty and shifts each one out as a UART frame: start bit, data LSB first, optional parity, stop bit. It runs entirely in the FIFO read-clock domain at one bit per clock cycle. The baud clock is supplied by the system clock divider.

---
 rtl/fifo_uart_tx_pkg.sv | 18 +
 rtl/tx_parity_calc.sv | 15 +
 rtl/fifo_uart_tx.sv | 104 ++++++++++
 tb/tb_fifo_uart_tx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: state encoding,
// parity-type constants and the default word width.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/tx_parity_calc.sv
// Combinational parity over a captured word; also used by the receive path
// to check incoming frames.
module tx_parity_calc
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity
);

  assign parity = (par_typ == PAR_ODD) ? ~^data : ^data;

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter on the FIFO read side: pops a word whenever the FIFO is
// non-empty and the line is free, then shifts it out one bit per clock.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] FIFO_DATA,
  input  logic                  FIFO_EMPTY,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  FIFO_INC,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(DATA_WIDTH - 1);

  state_t                  state, state_nx;
  logic [DATA_WIDTH-1:0]   data_q, data_nx;
  logic [CNT_WIDTH-1:0]    idx, idx_nx;
  logic                    par_en_q, par_en_nx;
  logic                    par_typ_q, par_typ_nx;
  logic                    tx_nx, busy_nx;
  logic                    parity;

  // Popping is allowed in STOP so consecutive frames run with no idle gap.
  assign FIFO_INC = RST & ~FIFO_EMPTY & ((state == ST_IDLE) | (state == ST_STOP));

  tx_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data    (data_q),
    .par_typ (par_typ_q),
    .parity  (parity)
  );

  always_comb begin
    state_nx   = state;
    data_nx    = data_q;
    idx_nx     = idx;
    par_en_nx  = par_en_q;
    par_typ_nx = par_typ_q;
    case (state)
      ST_IDLE, ST_STOP: begin
        if (FIFO_INC) begin
          state_nx   = ST_START;
          data_nx    = FIFO_DATA;
          par_en_nx  = PAR_EN;
          par_typ_nx = PAR_TYP;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_START: begin
        state_nx = ST_DATA;
        idx_nx   = '0;
      end
      ST_DATA: begin
        if (idx == LAST_IDX) state_nx = par_en_q ? ST_PARITY : ST_STOP;
        else                 idx_nx   = idx + CNT_WIDTH'(1);
      end
      ST_PARITY: state_nx = ST_STOP;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Line level and busy are decoded from the next state so the registered
  // outputs change exactly on the state boundary.
  always_comb begin
    tx_nx = 1'b1;
    case (state_nx)
      ST_START:  tx_nx = 1'b0;
      ST_DATA:   tx_nx = data_q[idx_nx];
      ST_PARITY: tx_nx = parity;
      default:   tx_nx = 1'b1;
    endcase
    busy_nx = (state_nx != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      data_q    <= '0;
      idx       <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
      TX_OUT    <= 1'b1;
      BUSY      <= 1'b0;
    end else begin
      state     <= state_nx;
      data_q    <= data_nx;
      idx       <= idx_nx;
      par_en_q  <= par_en_nx;
      par_typ_q <= par_typ_nx;
      TX_OUT    <= tx_nx;
      BUSY      <= busy_nx;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a queue stands in for the FIFO, and each
// frame is compared bit by bit against hand-written line sequences.
module tb_fifo_uart_tx;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] FIFO_DATA;
  logic       FIFO_EMPTY;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       FIFO_INC;
  logic       TX_OUT;
  logic       BUSY;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] q[$];

  fifo_uart_tx #(.DATA_WIDTH(8), .CNT_WIDTH(3)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .FIFO_DATA  (FIFO_DATA),
    .FIFO_EMPTY (FIFO_EMPTY),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .FIFO_INC   (FIFO_INC),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input logic obs, input logic exp, input string tag);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic fifo_upd();
    FIFO_EMPTY = (q.size() == 0);
    FIFO_DATA  = (q.size() == 0) ? 8'h00 : q[0];
  endtask

  task automatic push(input logic [7:0] d);
    q.push_back(d);
    fifo_upd();
  endtask

  // Advance one clock; the FIFO model pops if the strobe was high before the edge.
  task automatic step();
    logic inc;
    inc = FIFO_INC;
    @(posedge CLK);
    #1;
    if (inc && q.size() > 0) q.delete(0);
    fifo_upd();
    @(negedge CLK);
  endtask

  task automatic idle_chk(input string tag);
    chk(TX_OUT,   1'b1, {tag, "_tx"});
    chk(BUSY,     1'b0, {tag, "_busy"});
    chk(FIFO_INC, 1'b0, {tag, "_inc"});
  endtask

  // seq holds the line levels in transmission order, first bit at [len-1].
  task automatic frame(input logic [10:0] seq, input int len, input logic nxt_inc,
                       input int tog, input string tag);
    chk(FIFO_INC, 1'b1, {tag, "_pop"});
    for (int i = 0; i < len; i++) begin
      step();
      chk(TX_OUT, seq[len-1-i], $sformatf("%s_bit%0d", tag, i));
      chk(BUSY, 1'b1, $sformatf("%s_busy%0d", tag, i));
      chk(FIFO_INC, (i == len-1) ? nxt_inc : 1'b0, $sformatf("%s_inc%0d", tag, i));
      if (i == tog) begin
        PAR_EN  = ~PAR_EN;
        PAR_TYP = ~PAR_TYP;
      end
    end
  endtask

  initial begin
    RST = 1'b0;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    fifo_upd();
    @(negedge CLK);

    for (int i = 0; i < 20; i++) begin
      idle_chk($sformatf("rst%0d", i));
      step();
    end
    RST = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      idle_chk($sformatf("idle%0d", i));
      step();
    end

    // 0xA5 without parity
    push(8'hA5);
    #1;
    frame(11'b0101001011, 10, 1'b0, -1, "a5");
    step();
    idle_chk("a5_after");

    // 0xA5 with even, then odd parity
    PAR_EN = 1'b1;
    PAR_TYP = 1'b0;
    push(8'hA5);
    #1;
    frame(11'b01010010101, 11, 1'b0, -1, "a5e");
    step();
    idle_chk("a5e_after");
    PAR_TYP = 1'b1;
    push(8'hA5);
    #1;
    frame(11'b01010010111, 11, 1'b0, -1, "a5o");
    step();
    idle_chk("a5o_after");

    // three queued words back to back
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    push(8'h01);
    push(8'h80);
    push(8'hFF);
    #1;
    frame(11'b0100000001, 10, 1'b1, -1, "w01");
    frame(11'b0000000011, 10, 1'b1, -1, "w80");
    frame(11'b0111111111, 10, 1'b0, -1, "wff");
    step();
    idle_chk("b2b_after");

    // reset during data bit 3 of 0x3C
    push(8'h3C);
    #1;
    chk(FIFO_INC, 1'b1, "w3c_pop");
    for (int i = 0; i < 5; i++) begin
      logic [9:0] s3c;
      s3c = 10'b0001111001;
      step();
      chk(TX_OUT, s3c[9-i], $sformatf("w3c_bit%0d", i));
      chk(BUSY, 1'b1, $sformatf("w3c_busy%0d", i));
    end
    #2;
    RST = 1'b0;
    push(8'h5A);
    #1;
    idle_chk("midrst");
    step();
    idle_chk("midrst_hold");
    RST = 1'b1;
    #1;
    frame(11'b0010110101, 10, 1'b0, -1, "w5a");
    step();
    idle_chk("w5a_after");

    // config toggled mid-frame only affects the following frame
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    push(8'hC3);
    push(8'h07);
    #1;
    frame(11'b0110000111, 10, 1'b1, 3, "wc3");
    frame(11'b01110000001, 11, 1'b0, -1, "w07");
    step();
    idle_chk("w07_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
